// File: rtl/aes_decryptor.sv
`default_nettype none
// aes_decryptor: iterative AES-128 inverse cipher with CBC chaining, one round per clock.
// Rev 1.0 - initial release
module aes_decryptor #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int NUM_ROUNDS          = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] key_and_sync_key,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] key_and_sync_sync,
    input  logic                             key_and_sync_valid,
    output logic                             key_and_sync_rdy,
    input  logic [8*DATA_WIDTH_IN_BYTES-1:0] msg_in_data,
    input  logic                             msg_in_valid,
    input  logic                             msg_in_sop,
    input  logic                             msg_in_eop,
    input  logic [3:0]                       msg_in_empty,
    output logic                             msg_in_rdy,
    output logic [8*DATA_WIDTH_IN_BYTES-1:0] msg_out_data,
    output logic                             msg_out_valid,
    output logic                             msg_out_sop,
    output logic                             msg_out_eop,
    output logic [3:0]                       msg_out_empty,
    input  logic                             msg_out_rdy,
    output logic                             busy
);
    localparam int W = 8 * DATA_WIDTH_IN_BYTES;

    localparam logic [2:0] S_WAIT_KEY   = 3'd0;
    localparam logic [2:0] S_KEY_EXPAND = 3'd1;
    localparam logic [2:0] S_WAIT_BLOCK = 3'd2;
    localparam logic [2:0] S_DECRYPT    = 3'd3;
    localparam logic [2:0] S_OUTPUT     = 3'd4;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, s;
        r = 8'h01;
        s = a;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Walks the schedule backwards so decryption starts from key10 alone
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] p0, p1, p2, p3;
        p3 = k[31:0] ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        p0 = k[127:96] ^ sub_rot(p3) ^ {rc, 24'h0};
        return {p0, p1, p2, p3};
    endfunction

    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[c*4+r] = inv_sbox(s[127-8*(((c-r+4)%4)*4+r) -: 8]) ^ k[127-8*(c*4+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = b[c*4];
            a1 = b[c*4+1];
            a2 = b[c*4+2];
            a3 = b[c*4+3];
            if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
            else o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    logic [2:0]   state;
    logic [3:0]   rcnt;
    logic [W-1:0] rk, key10, chain, cblk, st;
    logic [W-1:0] rk_fwd, rk_prev, round_out;

    assign rk_fwd    = key_fwd(rk, rcon(rcnt));
    assign rk_prev   = key_inv(rk, rcon(rcnt));
    assign round_out = inv_round(st, rk_prev, rcnt == 4'd1);

    assign key_and_sync_rdy = (state == S_WAIT_KEY);
    assign msg_in_rdy       = (state == S_WAIT_BLOCK) && !msg_out_valid;
    assign busy             = (state != S_WAIT_KEY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_WAIT_KEY;
            rcnt          <= 4'd0;
            rk            <= '0;
            key10         <= '0;
            chain         <= '0;
            cblk          <= '0;
            st            <= '0;
            msg_out_data  <= '0;
            msg_out_valid <= 1'b0;
            msg_out_sop   <= 1'b0;
            msg_out_eop   <= 1'b0;
            msg_out_empty <= 4'd0;
        end else begin
            case (state)
                S_WAIT_KEY: begin
                    if (key_and_sync_valid) begin
                        rk    <= key_and_sync_key;
                        chain <= key_and_sync_sync;
                        rcnt  <= 4'd1;
                        state <= S_KEY_EXPAND;
                    end
                end
                S_KEY_EXPAND: begin
                    rk   <= rk_fwd;
                    rcnt <= rcnt + 4'd1;
                    if (rcnt == 4'(NUM_ROUNDS)) begin
                        key10 <= rk_fwd;
                        state <= S_WAIT_BLOCK;
                    end
                end
                S_WAIT_BLOCK: begin
                    if (msg_in_valid && msg_in_rdy) begin
                        cblk          <= msg_in_data;
                        st            <= msg_in_data ^ key10;
                        rk            <= key10;
                        rcnt          <= 4'(NUM_ROUNDS);
                        msg_out_sop   <= msg_in_sop;
                        msg_out_eop   <= msg_in_eop;
                        msg_out_empty <= msg_in_empty;
                        state         <= S_DECRYPT;
                    end
                end
                S_DECRYPT: begin
                    rk   <= rk_prev;
                    st   <= round_out;
                    rcnt <= rcnt - 4'd1;
                    if (rcnt == 4'd1) begin
                        msg_out_data  <= round_out ^ chain;
                        chain         <= cblk;
                        msg_out_valid <= 1'b1;
                        state         <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (msg_out_rdy) begin
                        msg_out_valid <= 1'b0;
                        state         <= msg_out_eop ? S_WAIT_KEY : S_WAIT_BLOCK;
                    end
                end
                default: state <= S_WAIT_KEY;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_decryptor.sv
`default_nettype none
// tb_aes_decryptor: known-answer and randomized CBC round-trip checks against a bench-side AES encryptor.
// Rev 1.0 - initial release
module tb_aes_decryptor;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_and_sync_key, key_and_sync_sync;
    logic         key_and_sync_valid, key_and_sync_rdy;
    logic [127:0] msg_in_data;
    logic         msg_in_valid, msg_in_sop, msg_in_eop, msg_in_rdy;
    logic [3:0]   msg_in_empty;
    logic [127:0] msg_out_data;
    logic         msg_out_valid, msg_out_sop, msg_out_eop, msg_out_rdy;
    logic [3:0]   msg_out_empty;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] sb [256];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C21 = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P21 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C22 = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] P22 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    aes_decryptor #(.DATA_WIDTH_IN_BYTES(16), .NUM_ROUNDS(10)) dut (
        .clk(clk), .rst(rst),
        .key_and_sync_key(key_and_sync_key), .key_and_sync_sync(key_and_sync_sync),
        .key_and_sync_valid(key_and_sync_valid), .key_and_sync_rdy(key_and_sync_rdy),
        .msg_in_data(msg_in_data), .msg_in_valid(msg_in_valid), .msg_in_sop(msg_in_sop),
        .msg_in_eop(msg_in_eop), .msg_in_empty(msg_in_empty), .msg_in_rdy(msg_in_rdy),
        .msg_out_data(msg_out_data), .msg_out_valid(msg_out_valid), .msg_out_sop(msg_out_sop),
        .msg_out_eop(msg_out_eop), .msg_out_empty(msg_out_empty), .msg_out_rdy(msg_out_rdy),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box from walking the generator 3 and its inverse around the multiplicative group
    function automatic void build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ xt(p);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [7:0]   s [4][4];
        logic [7:0]   n [4][4];
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [31:0]  t;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) n[r][c] = sb[s[r][(c+r)%4]];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = n[0][c]; a1 = n[1][c]; a2 = n[2][c]; a3 = n[3][c];
                    n[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    n[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    n[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    n[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = n[r][c] ^ w[4*rd+c][31-8*r -: 8];
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic load_key(input logic [127:0] k, input logic [127:0] iv, output int cycles);
        int n = 0;
        while (!key_and_sync_rdy && n < 100) begin @(posedge clk); #1; n++; end
        if (!key_and_sync_rdy) begin
            vectors++; miscompares++;
            $display("FAIL key_rdy_timeout: got rdy=%b, expected 1", key_and_sync_rdy);
        end
        key_and_sync_key = k; key_and_sync_sync = iv; key_and_sync_valid = 1'b1;
        @(posedge clk); #1;
        key_and_sync_valid = 1'b0;
        n = 0;
        while (!msg_in_rdy && n < 100) begin @(posedge clk); #1; n++; end
        cycles = n;
    endtask

    // lat counts clocks with the accepting handshake cycle as clock 1
    task automatic do_block(input logic [127:0] c, input logic s, input logic e,
                            input logic [3:0] emp, input int bp,
                            output logic [127:0] d, output logic os, output logic oe,
                            output logic [3:0] oemp, output int lat, output logic rdy_after,
                            output logic stable, output logic valid_after);
        int n = 0;
        msg_out_rdy  = (bp == 0);
        msg_in_data  = c; msg_in_sop = s; msg_in_eop = e; msg_in_empty = emp;
        msg_in_valid = 1'b1;
        while (!msg_in_rdy && n < 100) begin @(posedge clk); #1; n++; end
        if (!msg_in_rdy) begin
            vectors++; miscompares++;
            $display("FAIL msg_in_rdy_timeout: got rdy=%b, expected 1", msg_in_rdy);
        end
        @(posedge clk); #1;
        msg_in_valid = 1'b0;
        rdy_after    = msg_in_rdy;
        lat = 1;
        while (!msg_out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (!msg_out_valid) begin
            vectors++; miscompares++;
            $display("FAIL out_valid_timeout: got valid=%b, expected 1", msg_out_valid);
        end
        d = msg_out_data; os = msg_out_sop; oe = msg_out_eop; oemp = msg_out_empty;
        stable = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            if (msg_out_valid !== 1'b1 || msg_out_data !== d || msg_in_rdy !== 1'b0) stable = 1'b0;
        end
        msg_out_rdy = 1'b1;
        @(posedge clk); #1;
        valid_after = msg_out_valid;
    endtask

    logic [127:0] d;
    logic         os, oe, ra, stb, va;
    logic [3:0]   oemp;
    int           lat, kc;

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (key_and_sync_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_key_rdy: got %b, expected 1", key_and_sync_rdy); end
        vectors++; if (msg_in_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_in_rdy: got %b, expected 0", msg_in_rdy); end
        vectors++; if (msg_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, expected 0", msg_out_valid); end
        vectors++; if (msg_out_data !== 128'h0) begin miscompares++; $display("FAIL rst_data: got %h, expected 0", msg_out_data); end
        vectors++; if ({msg_out_sop, msg_out_eop, msg_out_empty} !== 6'h0) begin miscompares++; $display("FAIL rst_framing: got %b%b%h, expected 0", msg_out_sop, msg_out_eop, msg_out_empty); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        rst = 1'b1;
    endtask

    task automatic test_fips_c1();
        load_key(K1, 128'h0, kc);
        vectors++; if (kc !== 10) begin miscompares++; $display("FAIL key_expand_cycles: got %0d, expected 10", kc); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL c1_busy: got %b, expected 1", busy); end
        do_block(C1, 1'b1, 1'b1, 4'h0, 0, d, os, oe, oemp, lat, ra, stb, va);
        vectors++; if (d !== P1) begin miscompares++; $display("FAIL c1_data: got %h, expected %h", d, P1); end
        vectors++; if ({os, oe} !== 2'b11) begin miscompares++; $display("FAIL c1_sop_eop: got %b%b, expected 11", os, oe); end
        vectors++; if (lat !== 11) begin miscompares++; $display("FAIL c1_latency: got %0d, expected 11", lat); end
        vectors++; if (ra !== 1'b0) begin miscompares++; $display("FAIL c1_in_rdy_during_decrypt: got %b, expected 0", ra); end
        vectors++; if (va !== 1'b0) begin miscompares++; $display("FAIL c1_valid_after_handshake: got %b, expected 0", va); end
    endtask

    task automatic test_cbc_vectors();
        load_key(K2, K1, kc);
        do_block(C21, 1'b1, 1'b0, 4'h0, 0, d, os, oe, oemp, lat, ra, stb, va);
        vectors++; if (d !== P21) begin miscompares++; $display("FAIL cbc_p1: got %h, expected %h", d, P21); end
        vectors++; if ({os, oe} !== 2'b10) begin miscompares++; $display("FAIL cbc_p1_framing: got %b%b, expected 10", os, oe); end
        vectors++; if (key_and_sync_rdy !== 1'b0) begin miscompares++; $display("FAIL cbc_key_rdy_mid_msg: got %b, expected 0", key_and_sync_rdy); end
        do_block(C22, 1'b0, 1'b0, 4'h0, 0, d, os, oe, oemp, lat, ra, stb, va);
        vectors++; if (d !== P22) begin miscompares++; $display("FAIL cbc_p2: got %h, expected %h", d, P22); end
    endtask

    task automatic test_backpressure();
        logic [127:0] p, c;
        logic [3:0]   emp;
        p   = rnd128();
        emp = 4'($urandom_range(0, 15));
        c   = enc(p ^ C22, K2);
        do_block(c, 1'b0, 1'b1, emp, 5, d, os, oe, oemp, lat, ra, stb, va);
        vectors++; if (stb !== 1'b1) begin miscompares++; $display("FAIL bp_hold_stable: got %b, expected 1", stb); end
        vectors++; if (d !== p) begin miscompares++; $display("FAIL bp_data: got %h, expected %h", d, p); end
        vectors++; if ({oe, oemp} !== {1'b1, emp}) begin miscompares++; $display("FAIL bp_eop_empty: got %b/%h, expected 1/%h", oe, oemp, emp); end
        vectors++; if (va !== 1'b0) begin miscompares++; $display("FAIL bp_valid_after: got %b, expected 0", va); end
    endtask

    task automatic test_key_reload();
        vectors++; if (key_and_sync_rdy !== 1'b1) begin miscompares++; $display("FAIL reload_key_rdy: got %b, expected 1", key_and_sync_rdy); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reload_busy: got %b, expected 0", busy); end
        load_key(K1, 128'h0, kc);
        do_block(C1, 1'b1, 1'b1, 4'h0, 0, d, os, oe, oemp, lat, ra, stb, va);
        vectors++; if (d !== P1) begin miscompares++; $display("FAIL reload_data: got %h, expected %h", d, P1); end
    endtask

    task automatic test_reset_mid_decrypt();
        int n = 0;
        load_key(K1, 128'h0, kc);
        msg_in_data = C1; msg_in_sop = 1'b1; msg_in_eop = 1'b1; msg_in_empty = 4'h0;
        msg_in_valid = 1'b1;
        while (!msg_in_rdy && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        msg_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b, expected 1", busy); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b, expected 0", busy); end
        vectors++; if (key_and_sync_rdy !== 1'b1) begin miscompares++; $display("FAIL mid_key_rdy: got %b, expected 1", key_and_sync_rdy); end
        vectors++; if (msg_in_rdy !== 1'b0) begin miscompares++; $display("FAIL mid_in_rdy: got %b, expected 0", msg_in_rdy); end
        vectors++; if ({msg_out_valid, msg_out_data} !== 129'h0) begin miscompares++; $display("FAIL mid_out: got %b/%h, expected 0/0", msg_out_valid, msg_out_data); end
        vectors++; if ({msg_out_sop, msg_out_eop} !== 2'b00) begin miscompares++; $display("FAIL mid_framing: got %b%b, expected 00", msg_out_sop, msg_out_eop); end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        vectors++; if (msg_out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_leftover: got %b, expected 0", msg_out_valid); end
        load_key(K1, 128'h0, kc);
        do_block(C1, 1'b1, 1'b1, 4'h0, 0, d, os, oe, oemp, lat, ra, stb, va);
        vectors++; if (d !== P1) begin miscompares++; $display("FAIL mid_reload_data: got %h, expected %h", d, P1); end
    endtask

    task automatic test_random_messages();
        logic [127:0] k, iv, chain, p, c;
        logic [3:0]   emp;
        logic         s, e;
        int           len;
        for (int m = 0; m < 6; m++) begin
            k = rnd128(); iv = rnd128(); chain = iv;
            len = $urandom_range(1, 4);
            load_key(k, iv, kc);
            for (int b = 0; b < len; b++) begin
                p   = rnd128();
                c   = enc(p ^ chain, k);
                chain = c;
                s   = (b == 0);
                e   = (b == len - 1);
                emp = 4'($urandom_range(0, 15));
                do_block(c, s, e, emp, $urandom_range(0, 3), d, os, oe, oemp, lat, ra, stb, va);
                vectors++; if (d !== p) begin miscompares++; $display("FAIL rand_data m%0d b%0d: got %h, expected %h", m, b, d, p); end
                vectors++; if ({os, oe, oemp} !== {s, e, emp}) begin miscompares++; $display("FAIL rand_framing m%0d b%0d: got %b%b%h, expected %b%b%h", m, b, os, oe, oemp, s, e, emp); end
                vectors++; if (lat !== 11) begin miscompares++; $display("FAIL rand_latency m%0d b%0d: got %0d, expected 11", m, b, lat); end
            end
            vectors++; if (key_and_sync_rdy !== 1'b1) begin miscompares++; $display("FAIL rand_key_rdy_end m%0d: got %b, expected 1", m, key_and_sync_rdy); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        build_sbox();
        rst = 1'b0;
        key_and_sync_key = '0; key_and_sync_sync = '0; key_and_sync_valid = 1'b0;
        msg_in_data = '0; msg_in_valid = 1'b0; msg_in_sop = 1'b0; msg_in_eop = 1'b0;
        msg_in_empty = 4'h0; msg_out_rdy = 1'b1;
        test_reset();
        test_fips_c1();
        test_cbc_vectors();
        test_backpressure();
        test_key_reload();
        test_reset_mid_decrypt();
        test_random_messages();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
